// File: rtl/sdram_device_model.sv
// Synthesizable stand-in for a 16-bit single-chip SDRAM: decodes the command bus, tracks
// open rows, holds the mode register, serves CAS-latency bursts and flags protocol errors.
module sdram_device_model #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sdram_ncs,
    input  logic        sdram_nras,
    input  logic        sdram_ncas,
    input  logic        sdram_nwe,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_a,
    input  logic [1:0]  sdram_dqm,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic [1:0]  dq_oe,
    output logic        mode_loaded,
    output logic [15:0] refresh_cnt,
    output logic [3:0]  err
);
    localparam int ADDR_W = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [2:0] CMD_LMR = 3'b000;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;

    // One scheduled or running read burst; bsh is log2 of the burst length.
    typedef struct packed {
        logic                vld;
        logic [1:0]          ba;
        logic [ROW_BITS-1:0] row;
        logic [COL_BITS-1:0] col;
        logic [1:0]          bsh;
        logic [1:0]          oe;
    } rd_t;

    logic [15:0]         r_mem [0:DEPTH-1];
    logic [3:0]          r_open;
    logic [ROW_BITS-1:0] r_row [0:3];
    logic [9:0]          r_mode;
    logic                r_mode_loaded;
    logic [15:0]         r_refresh_cnt;
    logic [3:0]          r_err;
    logic [15:0]         r_dq_out;
    logic [1:0]          r_dq_oe;
    rd_t                 r_p1;
    rd_t                 r_p2;
    rd_t                 r_cur;
    logic [2:0]          r_cur_k;

    logic [2:0]          w_cmd;
    logic                w_act;
    logic                w_rd;
    logic                w_wr;
    logic                w_pre;
    logic                w_ref;
    logic                w_lmr;
    logic                w_bank_open;
    logic                w_cl2;
    logic [3:0]          w_err;
    rd_t                 w_new_rd;
    rd_t                 w_src;
    logic [2:0]          w_k;
    logic [2:0]          w_last;
    logic                w_beat_vld;
    logic [ADDR_W-1:0]   w_beat_addr;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [15:0]         w_beat_data;
    logic                w_unused_bits;

    function automatic logic [1:0] f_bl_shift(input logic [2:0] code);
        case (code)
            3'b001:  f_bl_shift = 2'd1;
            3'b010:  f_bl_shift = 2'd2;
            3'b011:  f_bl_shift = 2'd3;
            default: f_bl_shift = 2'd0;
        endcase
    endfunction

    // Sequential ordering: beat k wraps inside the BL-aligned block of columns.
    function automatic logic [COL_BITS-1:0] f_beat_col(input logic [COL_BITS-1:0] col,
                                                       input logic [1:0] bsh,
                                                       input logic [2:0] k);
        logic [COL_BITS-1:0] m;
        m = ~({COL_BITS{1'b1}} << bsh);
        f_beat_col = (col & ~m) | ((col + COL_BITS'(k)) & m);
    endfunction

    assign w_cmd         = sdram_ncs ? 3'b111 : {sdram_nras, sdram_ncas, sdram_nwe};
    assign w_bank_open   = r_open[sdram_ba];
    assign w_cl2         = r_mode_loaded && (r_mode[6:4] == 3'd2);
    assign w_wr_addr     = {sdram_ba, r_row[sdram_ba], sdram_a[COL_BITS-1:0]};
    assign w_unused_bits = ^{sdram_a[12:11], r_mode[9:7], r_mode[3]};

    // Command decode and one-cycle protocol-violation flags.
    always_comb begin
        w_act = 1'b0;
        w_rd  = 1'b0;
        w_wr  = 1'b0;
        w_pre = 1'b0;
        w_ref = 1'b0;
        w_lmr = 1'b0;
        case (w_cmd)
            CMD_ACT: w_act = 1'b1;
            CMD_RD:  w_rd  = 1'b1;
            CMD_WR:  w_wr  = 1'b1;
            CMD_PRE: w_pre = 1'b1;
            CMD_REF: w_ref = 1'b1;
            CMD_LMR: w_lmr = 1'b1;
            default: w_act = 1'b0;
        endcase
        w_err[0] = (w_rd || w_wr) && !w_bank_open;
        w_err[1] = w_act && w_bank_open;
        w_err[2] = w_ref && (r_open != 4'b0000);
        w_err[3] = (w_rd || w_wr) && !r_mode_loaded;
    end

    // Burst descriptor for a READ accepted this edge; unloaded mode forces BL = 1.
    always_comb begin
        w_new_rd     = '0;
        w_new_rd.vld = w_rd && w_bank_open;
        w_new_rd.ba  = sdram_ba;
        w_new_rd.row = r_row[sdram_ba];
        w_new_rd.col = sdram_a[COL_BITS-1:0];
        w_new_rd.bsh = r_mode_loaded ? f_bl_shift(r_mode[2:0]) : 2'd0;
        w_new_rd.oe  = ~sdram_dqm;
    end

    // A burst whose first beat is due now takes over from the running one.
    always_comb begin
        if (r_p1.vld) begin
            w_src = r_p1;
            w_k   = 3'd0;
        end else begin
            w_src = r_cur;
            w_k   = r_cur_k;
        end
        w_last     = ~(3'b111 << w_src.bsh);
        w_beat_vld = w_src.vld && !w_wr;
    end

    assign w_beat_addr = {w_src.ba, w_src.row, f_beat_col(w_src.col, w_src.bsh, w_k)};
    assign w_beat_data = r_mem[w_beat_addr];

    // Array write port with byte masks; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr && w_bank_open) begin
            if (!sdram_dqm[0]) r_mem[w_wr_addr][7:0]  <= dq_in[7:0];
            if (!sdram_dqm[1]) r_mem[w_wr_addr][15:8] <= dq_in[15:8];
        end
    end

    // Bank/row tracking, mode register, refresh counter and error pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_open        <= 4'b0000;
            for (int i = 0; i < 4; i++) r_row[i] <= {ROW_BITS{1'b0}};
            r_mode        <= 10'h000;
            r_mode_loaded <= 1'b0;
            r_refresh_cnt <= 16'h0000;
            r_err         <= 4'b0000;
        end else begin
            r_err <= w_err;
            if (w_act) begin
                r_open[sdram_ba] <= 1'b1;
                r_row[sdram_ba]  <= sdram_a[ROW_BITS-1:0];
            end
            if (w_pre) begin
                if (sdram_a[10]) r_open <= 4'b0000;
                else             r_open[sdram_ba] <= 1'b0;
            end
            if (w_ref && (r_open == 4'b0000)) r_refresh_cnt <= r_refresh_cnt + 16'd1;
            if (w_lmr) begin
                r_mode        <= sdram_a[9:0];
                r_mode_loaded <= 1'b1;
            end
        end
    end

    // Read pipeline: p2/p1 delay a READ by CL-1 edges, r_cur streams the remaining beats.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1     <= '0;
            r_p2     <= '0;
            r_cur    <= '0;
            r_cur_k  <= 3'd0;
            r_dq_out <= 16'h0000;
            r_dq_oe  <= 2'b00;
        end else if (w_wr) begin
            r_p1    <= '0;
            r_p2    <= '0;
            r_cur   <= '0;
            r_dq_oe <= 2'b00;
        end else begin
            r_p1 <= r_p2;
            r_p2 <= '0;
            if (w_new_rd.vld) begin
                if (w_cl2) r_p1 <= w_new_rd;
                else       r_p2 <= w_new_rd;
            end
            if (w_beat_vld) begin
                r_dq_out <= w_beat_data;
                r_dq_oe  <= w_src.oe;
                r_cur    <= w_src;
                r_cur_k  <= w_k + 3'd1;
                if (w_k == w_last) r_cur.vld <= 1'b0;
            end else begin
                r_dq_oe <= 2'b00;
            end
        end
    end

    assign dq_out      = r_dq_out;
    assign dq_oe       = r_dq_oe;
    assign mode_loaded = r_mode_loaded;
    assign refresh_cnt = r_refresh_cnt;
    assign err         = r_err;

endmodule

// File: tb/tb_sdram_device_model.sv
// Randomized bench for sdram_device_model against an edge-indexed reference model:
// each READ books its beats on absolute future edges, later READs/WRITEs overwrite the booking.
module tb_sdram_device_model;
    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_BST = 3'b110;
    localparam logic [2:0] C_NOP = 3'b111;
    localparam int MAXE = 8192;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_dqm;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic [1:0]  dq_oe;
    logic        mode_loaded;
    logic [15:0] refresh_cnt;
    logic [3:0]  err;

    always #5 clk = ~clk;

    sdram_device_model #(.ROW_BITS(4), .COL_BITS(6)) dut (
        .clk(clk), .reset_n(reset_n), .sdram_ncs(sdram_ncs), .sdram_nras(sdram_nras),
        .sdram_ncas(sdram_ncas), .sdram_nwe(sdram_nwe), .sdram_ba(sdram_ba), .sdram_a(sdram_a),
        .sdram_dqm(sdram_dqm), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
        .mode_loaded(mode_loaded), .refresh_cnt(refresh_cnt), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    // Reference state
    logic [15:0] m_mem [4096];
    logic [1:0]  m_kn  [4096];
    bit          m_open [4];
    int          m_row [4];
    logic [9:0]  m_mode;
    bit          m_loaded;
    int          m_ref;
    bit          s_vld [MAXE];
    logic [15:0] s_dat [MAXE];
    bit          s_kn  [MAXE];
    logic [1:0]  s_oe  [MAXE];
    logic [1:0]  e_oe;
    logic [15:0] e_out;
    bit          e_kn;
    logic [3:0]  e_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    function automatic int blen(input logic [2:0] code);
        case (code)
            3'b001:  return 2;
            3'b010:  return 4;
            3'b011:  return 8;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = 0;
        end
        m_mode = 10'h000;
        m_loaded = 1'b0;
        m_ref = 0;
        for (int t = 0; t < MAXE; t++) s_vld[t] = 1'b0;
        e_oe = 2'b00;
        e_out = 16'h0000;
        e_kn = 1'b1;
        e_err = 4'b0000;
    endtask

    task automatic model_step(input logic csn, input logic [2:0] cmd, input logic [1:0] b,
                              input logic [12:0] addr, input logic [1:0] m, input logic [15:0] d);
        logic [2:0] c;
        int idx, cl, bl, t0, col, ck;
        c = csn ? C_NOP : cmd;
        e_err = 4'b0000;
        col = int'(addr[8:0]);
        case (c)
            C_ACT: begin
                if (m_open[b]) e_err[1] = 1'b1;
                m_open[b] = 1'b1;
                m_row[b] = int'(addr);
            end
            C_RD, C_WR: begin
                if (!m_open[b]) e_err[0] = 1'b1;
                if (!m_loaded) e_err[3] = 1'b1;
                if (c == C_WR) begin
                    for (int t = edge_n; t < edge_n + 12; t++) s_vld[t] = 1'b0;
                    if (m_open[b]) begin
                        idx = int'(b) * 1024 + (m_row[b] % 16) * 64 + col % 64;
                        if (!m[0]) begin m_mem[idx][7:0]  = d[7:0];  m_kn[idx][0] = 1'b1; end
                        if (!m[1]) begin m_mem[idx][15:8] = d[15:8]; m_kn[idx][1] = 1'b1; end
                    end
                end else if (m_open[b]) begin
                    cl = (m_loaded && m_mode[6:4] == 3'd2) ? 2 : 3;
                    bl = m_loaded ? blen(m_mode[2:0]) : 1;
                    t0 = edge_n + cl - 1;
                    for (int t = t0; t < t0 + 12; t++) s_vld[t] = 1'b0;
                    for (int k = 0; k < bl; k++) begin
                        ck = (col / bl) * bl + ((col % bl) + k) % bl;
                        idx = int'(b) * 1024 + (m_row[b] % 16) * 64 + ck % 64;
                        s_vld[t0 + k] = 1'b1;
                        s_dat[t0 + k] = m_mem[idx];
                        s_kn[t0 + k]  = (m_kn[idx] == 2'b11);
                        s_oe[t0 + k]  = ~m;
                    end
                end
            end
            C_PRE: begin
                if (addr[10]) for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
                else m_open[b] = 1'b0;
            end
            C_REF: begin
                if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) e_err[2] = 1'b1;
                else m_ref = (m_ref + 1) % 65536;
            end
            C_LMR: begin
                m_mode = addr[9:0];
                m_loaded = 1'b1;
            end
            default: ;
        endcase
        if (s_vld[edge_n]) begin
            e_oe = s_oe[edge_n];
            e_out = s_dat[edge_n];
            e_kn = s_kn[edge_n];
        end else begin
            e_oe = 2'b00;
        end
    endtask

    task automatic compare_outputs();
        check_val("dq_oe", dq_oe, e_oe);
        check_val("err", err, e_err);
        check_val("refresh_cnt", refresh_cnt, m_ref[15:0]);
        check_val("mode_loaded", mode_loaded, m_loaded);
        if (e_kn) check_val("dq_out", dq_out, e_out);
    endtask

    task automatic tick(input logic csn, input logic [2:0] cmd, input logic [1:0] b,
                        input logic [12:0] addr, input logic [1:0] m, input logic [15:0] d);
        sdram_ncs = csn;
        {sdram_nras, sdram_ncas, sdram_nwe} = cmd;
        sdram_ba = b;
        sdram_a = addr;
        sdram_dqm = m;
        dq_in = d;
        @(posedge clk);
        edge_n++;
        model_step(csn, cmd, b, addr, m, d);
        #1;
        compare_outputs();
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr,
                       input logic [1:0] m, input logic [15:0] d);
        tick(1'b0, c, b, addr, m, d);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, C_NOP, 2'd0, 13'h0000, 2'b00, 16'h0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  c;
        logic        csn;
        logic [1:0]  b, m;
        logic [12:0] addr;
        logic [15:0] d;
        int r;

        for (int i = 0; i < 4096; i++) m_kn[i] = 2'b00;
        reset_n = 1'b0;
        sdram_ncs = 1'b1;
        {sdram_nras, sdram_ncas, sdram_nwe} = C_NOP;
        sdram_ba = 2'd0;
        sdram_a = 13'h0000;
        sdram_dqm = 2'b00;
        dq_in = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        edge_n = 2;
        #1;
        compare_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Init
        cmd(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0000);
        cmd(C_REF, 2'd0, 13'h0000, 2'b00, 16'h0000);
        cmd(C_REF, 2'd0, 13'h0000, 2'b00, 16'h0000);
        cmd(C_LMR, 2'd0, 13'h0230, 2'b00, 16'h0000);
        check_val("init_refcnt", refresh_cnt, 32'd2);
        check_val("init_loaded", mode_loaded, 32'd1);

        // CL3 BL1 write/read
        cmd(C_ACT, 2'd1, 13'd5, 2'b00, 16'h0000);
        cmd(C_WR, 2'd1, 13'd3, 2'b00, 16'hA55A);
        nop(1);
        cmd(C_RD, 2'd1, 13'd3, 2'b00, 16'h0000);
        nop(1);
        check_val("cl3_early_oe", dq_oe, 32'd0);
        nop(1);
        check_val("cl3_oe", dq_oe, 32'd3);
        check_val("cl3_data", dq_out, 32'hA55A);
        nop(1);
        check_val("cl3_end_oe", dq_oe, 32'd0);

        // Byte masks
        cmd(C_WR, 2'd1, 13'd4, 2'b00, 16'h1234);
        cmd(C_WR, 2'd1, 13'd4, 2'b10, 16'hFFFF);
        cmd(C_RD, 2'd1, 13'd4, 2'b00, 16'h0000);
        nop(2);
        check_val("mask_data", dq_out, 32'h12FF);
        nop(1);
        cmd(C_RD, 2'd1, 13'd4, 2'b01, 16'h0000);
        nop(2);
        check_val("mask_oe", dq_oe, 32'd2);
        nop(2);

        // BL4 CL2 wrapped burst
        cmd(C_LMR, 2'd0, 13'h0222, 2'b00, 16'h0000);
        for (int k = 0; k < 4; k++) cmd(C_WR, 2'd1, 13'(k), 2'b00, 16'(k));
        cmd(C_RD, 2'd1, 13'd2, 2'b00, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            nop(1);
            check_val("bl4_oe", dq_oe, 32'd3);
            check_val("bl4_data", dq_out, 32'((k + 2) % 4));
        end
        nop(1);
        check_val("bl4_end_oe", dq_oe, 32'd0);

        // Violations
        cmd(C_RD, 2'd2, 13'd0, 2'b00, 16'h0000);
        check_val("closed_rd_err", err, 32'h1);
        nop(3);
        cmd(C_ACT, 2'd1, 13'd7, 2'b00, 16'h0000);
        check_val("dup_act_err", err, 32'h2);
        cmd(C_REF, 2'd0, 13'h0000, 2'b00, 16'h0000);
        check_val("ref_open_err", err, 32'h4);
        check_val("ref_open_cnt", refresh_cnt, 32'd2);

        // Reset during beat 1 of a BL8 read
        cmd(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0000);
        cmd(C_LMR, 2'd0, 13'h0023, 2'b00, 16'h0000);
        cmd(C_ACT, 2'd0, 13'd0, 2'b00, 16'h0000);
        for (int k = 0; k < 8; k++) cmd(C_WR, 2'd0, 13'(k), 2'b00, 16'(16'h0100 + k));
        cmd(C_RD, 2'd0, 13'd0, 2'b00, 16'h0000);
        nop(2);
        check_val("beat1_data", dq_out, 32'h0101);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_async_oe", dq_oe, 32'd0);
        check_val("rst_async_dq", dq_out, 32'd0);
        @(posedge clk);
        edge_n++;
        #1;
        check_val("rst_hold_oe", dq_oe, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        nop(10);

        // Randomized traffic
        cmd(C_LMR, 2'd0, 13'h0232, 2'b00, 16'h0000);
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 99);
            csn = 1'b0;
            b = 2'($urandom_range(0, 3));
            addr = 13'($urandom);
            m = 2'($urandom_range(0, 3));
            d = 16'($urandom);
            if (r < 10) begin
                c = C_ACT;
                addr = (addr & 13'h1FF0) | 13'($urandom_range(0, 1));
            end else if (r < 38) begin
                c = C_RD;
                addr = (addr & 13'h1DC0) | 13'($urandom_range(0, 15));
            end else if (r < 60) begin
                c = C_WR;
                addr = (addr & 13'h1DC0) | 13'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) m = 2'b00;
            end else if (r < 68) begin
                c = C_PRE;
            end else if (r < 72) begin
                c = C_REF;
            end else if (r < 75) begin
                c = C_LMR;
                if ($urandom_range(0, 1) == 1) addr[6:4] = 3'd2;
            end else if (r < 78) begin
                c = C_BST;
            end else if (r < 82) begin
                c = 3'($urandom_range(0, 7));
                csn = 1'b1;
            end else begin
                c = C_NOP;
            end
            tick(csn, c, b, addr, m, d);
        end
        nop(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_device_model.md
Name: sdram_device_model

Overview:
- Synthesizable responder for the 16-bit single-chip SDRAM command bus that our SDRAM controller drives.
- Decodes the CS/RAS/CAS/WE command stream, tracks open rows per bank, and holds the mode register.
- Serves reads and writes from a small internal array with correct CAS latency, burst and DQM behaviour.
- Used in simulation and on-FPGA loopback benches in place of the external chip. It also flags protocol violations so controller regressions surface as error pulses.

Parameters:
- ROW_BITS, 4: row address bits kept (upper row bits ignored).
- COL_BITS, 6: column address bits kept (upper column bits ignored).
- Array depth is 2^(2+ROW_BITS+COL_BITS) 16-bit words.
- Word index is {ba, row[ROW_BITS-1:0], col[COL_BITS-1:0]}.

Ports:
- clk  in  1  same clock as the controller; all sampling on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sdram_ncs  in  1  chip select; commands are ignored when high.
- sdram_nras  in  1  row address strobe.
- sdram_ncas  in  1  column address strobe.
- sdram_nwe  in  1  write enable.
- sdram_ba  in  2  bank address.
- sdram_a  in  13  multiplexed address.
- sdram_dqm  in  2  byte masks, {DQMH, DQML}.
- dq_in  in  16  data from the controller (tristate resolved by the wrapper).
- dq_out  out  16  read data.
- dq_oe  out  2  per-byte output enable for dq_out.
- mode_loaded  out  1  set by the first LOAD_MODE.
- refresh_cnt  out  16  count of accepted AUTO_REFRESH commands.
- err  out  4  one-cycle error pulses:
  - [0] READ/WRITE to a closed bank.
  - [1] ACTIVE to an already-open bank.
  - [2] AUTO_REFRESH while any bank is open.
  - [3] READ/WRITE before mode_loaded.

Behaviour:
- Reset (asynchronous, on reset_n low):
  - All banks closed; mode = 10'h000; mode_loaded = 0.
  - dq_out = 0; dq_oe = 0; refresh_cnt = 0; err = 0.
  - Burst pipeline cleared.
  - Array contents are not reset.
- Command decode: {nras, ncas, nwe} sampled when ncs = 0.
  - 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO_REFRESH, 000 LOAD_MODE.
  - 110 (burst terminate) is treated as NOP.
- ACTIVE: open[ba] <= 1 and row[ba] <= a. If the bank was already open, pulse err[1]; the row is still replaced.
- PRECHARGE: a[10] = 1 closes all banks; otherwise closes bank ba only. An in-flight read burst is not truncated.
- AUTO_REFRESH:
  - If no bank is open, refresh_cnt increments (wraps at 16'hFFFF -> 0).
  - If any bank is open, pulse err[2] and do not count.
- LOAD_MODE: mode <= a[9:0]; mode_loaded <= 1. Allowed at any time; takes effect for the next READ.
- Mode fields:
  - CAS latency CL = mode[6:4]; value 2 gives CL = 2, any other value gives CL = 3.
  - Burst length BL = 1/2/4/8 for mode[2:0] = 000/001/010/011; other codes give BL = 1.
  - Ordering is always sequential (mode[3] ignored).
  - Writes are always single-beat, regardless of mode[9].
- WRITE at edge N:
  - Column = a[8:0]; bank must be open.
  - Write dq_in byte lanes whose dqm bit is 0 into {ba, row[ba], col}.
  - Closed bank: pulse err[0], no write. Before mode_loaded: pulse err[3], write still performed if the bank is open.
- READ at edge N:
  - Closed bank: pulse err[0], no data. Before mode_loaded: pulse err[3], read still performed with CL = 3, BL = 1.
  - Beat k (0..BL-1) is read from column {col[8:b], (col[b-1:0] + k) mod BL}, where b = log2(BL). The burst wraps within its BL-aligned block.
  - Beat k is registered so that dq_out/dq_oe are valid after edge N+CL-1+k. The controller samples it at edge N+CL+k.
  - dq_oe = ~dqm as sampled at the READ edge, held for the whole burst.
  - After the last beat, dq_oe = 0 and dq_out holds its last value.
- Simultaneous and overlapping events:
  - A READ arriving during an active burst truncates the old burst; beats from the new READ take over at their scheduled edges.
  - A WRITE during a read burst performs the write and truncates the burst from that edge (dq_oe = 0 thereafter).
  - A read of a word written on the same edge returns the new data.
- Reset mid-burst: dq_oe drops immediately (asynchronous); no further beats are output.

Test Plan:
- Init: PRECHARGE all, 2x AUTO_REFRESH, LOAD_MODE a = 13'h230 -> refresh_cnt = 2, mode_loaded = 1, err = 0.
- Write/read, CL = 3, BL = 1:
  - ACTIVE ba = 1 row 5; WRITE col 3, data 16'hA55A, dqm 00; READ col 3 at edge N.
  - Expect dq_out = 16'hA55A with dq_oe = 11 for exactly one cycle after edge N+2.
- Byte mask:
  - Write 16'h1234, then write 16'hFFFF with dqm = 10.
  - READ with dqm = 00 -> 16'h12FF; READ with dqm = 01 -> dq_oe = 10.
- Burst BL = 4, CL = 2:
  - LOAD_MODE a = 13'h222; fill cols 0..3 with 16'h0000..16'h0003; READ col 2.
  - Expect beats 16'h0002, 16'h0003, 16'h0000, 16'h0001 on consecutive cycles starting after edge N+1.
- Violations:
  - READ to a closed bank -> err = 4'b0001, no dq_oe.
  - Second ACTIVE to the same bank -> err[1].
  - AUTO_REFRESH with a bank open -> err[2], refresh_cnt unchanged.
- Reset mid-burst: assert reset_n low during beat 1 of a BL = 8 read -> dq_oe = 0 in the same cycle, and no beats after release.
